// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_phy_pkg
//  Description : Shared constants and state encoding for the PHY transmit
//                byte and bit-level stages (symbol width, COM symbol,
//                serializer state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package pcie_phy_pkg;

    // Symbol width in bits; the serializer only supports 8.
    localparam int DATA_W = 8;

    // K28.5 comma symbol, sent while idle and during link sync.
    localparam logic [DATA_W-1:0] COM_SYM = 8'hBC;

    // Serializer state encoding: SYNC sends COM only, ACTIVE accepts data.
    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/par_serial_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : par_serial_tx_if
//  Description : Byte-in / bit-out bundle of the transmit serializer.
//                master : upstream 32-to-8 stage (drives data_in/valid_in)
//                slave  : par_serial_tx (drives data_out/load_strb/active)
//  Signals     : data_in[DATA_W], valid_in, data_out, load_strb, active
//  Revision    : 1.0 - initial release
// ============================================================================
interface par_serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              data_out;
    logic              load_strb;
    logic              active;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  load_strb,
        input  active
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output load_strb,
        output active
    );
endinterface
`default_nettype wire

// File: rtl/piso_shift8.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift8
//  Description : 8-bit parallel-load shift register, MSB first. On a load
//                edge din[7] goes straight to the registered output and the
//                remaining seven bits are queued behind it.
//  Ports       : clk   - bit clock
//                reset - synchronous, active-low
//                load  - parallel load of din at this edge
//                din   - parallel symbol
//                dout  - registered serial bit
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    output logic       dout
);

    logic [7:0] r_shift;
    logic       r_dout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '0;
            r_dout  <= 1'b0;
        end else if (load) begin
            // MSB leaves on the load edge itself, so the queue holds bits 6..0.
            r_dout  <= din[7];
            r_shift <= {din[6:0], 1'b0};
        end else begin
            r_dout  <= r_shift[7];
            r_shift <= {r_shift[6:0], 1'b0};
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/par_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : par_serial_tx
//  Description : Transmit-lane serializer. Samples a byte every 8 bit clocks
//                and shifts it out MSB first; sends COM when no valid byte
//                is offered. After reset, SYNC_COUNT COM symbols are sent
//                before data is accepted.
//  Ports       : clk_32f - bit clock (8x byte rate)
//                reset   - synchronous, active-low
//                bus     - par_serial_tx_if slave (data_in, valid_in,
//                          data_out, load_strb, active)
//  Revision    : 1.0 - initial release
// ============================================================================
module par_serial_tx #(
    parameter int                DATA_W     = pcie_phy_pkg::DATA_W,
    parameter logic [DATA_W-1:0] COM_SYM    = pcie_phy_pkg::COM_SYM,
    parameter int                SYNC_COUNT = 4
) (
    input  logic           clk_32f,
    input  logic           reset,
    par_serial_tx_if.slave bus
);
    import pcie_phy_pkg::*;

    localparam int                  c_SCNT_W    = $clog2(SYNC_COUNT + 1);
    localparam logic [c_SCNT_W-1:0] c_SYNC_LAST = c_SCNT_W'(SYNC_COUNT - 1);

    logic [2:0]          r_bit_cnt;
    logic [c_SCNT_W-1:0] r_sync_cnt;
    logic [c_SCNT_W-1:0] w_sync_cnt_nxt;
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_active;
    logic                w_active_nxt;
    logic                w_load;
    logic [DATA_W-1:0]   w_next_sym;

    // Byte boundary: counter at zero, and never while reset is held.
    assign w_load        = (r_bit_cnt == 3'd0) && reset;
    assign bus.load_strb = w_load;
    assign bus.active    = r_active;

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_bit_cnt  <= '0;
            r_sync_cnt <= '0;
            r_state    <= ST_SYNC;
            r_active   <= 1'b0;
        end else begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_sync_cnt <= w_sync_cnt_nxt;
            r_state    <= w_state_nxt;
            r_active   <= w_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        w_active_nxt   = r_active;
        w_next_sym     = COM_SYM;
        case (r_state)
            ST_SYNC: begin
                // Count COM symbols as they are launched; the last one flips
                // the lane to ACTIVE so the following load can take data.
                if (w_load) begin
                    w_sync_cnt_nxt = r_sync_cnt + c_SCNT_W'(1);
                    if (r_sync_cnt == c_SYNC_LAST) begin
                        w_state_nxt  = ST_ACTIVE;
                        w_active_nxt = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                w_active_nxt = 1'b1;
                if (bus.valid_in) begin
                    w_next_sym = bus.data_in;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    piso_shift8 u_piso (
        .clk   (clk_32f),
        .reset (reset),
        .load  (w_load),
        .din   (w_next_sym),
        .dout  (bus.data_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_par_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_par_serial_tx
//  Description : Self-checking bench for par_serial_tx. A symbol table covers
//                sync, data, back-to-back and re-sync cases; hand sequences
//                cover mid-symbol input changes and mid-symbol reset; a
//                random phase runs against a bit-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_par_serial_tx;

    localparam int          SYNC_COUNT = 4;
    localparam logic [7:0]  COM        = 8'hBC;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;

    par_serial_tx_if #(.DATA_W(8)) bus ();

    par_serial_tx #(
        .DATA_W     (8),
        .COM_SYM    (COM),
        .SYNC_COUNT (SYNC_COUNT)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int total = 0;
    int bad   = 0;

    // Reference model: n = edges since reset release; q = bits still owed.
    int   n = 0;
    logic q[$];
    logic exp_do  = 1'b0;
    logic exp_act = 1'b0;

    typedef struct {
        logic       rst_before;
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp_sym;
        logic       exp_act;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One bit clock. Inputs must already be set for this edge.
    task automatic tick();
        logic [7:0] sym;
        #1;
        check("load_strb", 32'(bus.load_strb), 32'(reset && (n % 8 == 0)));
        if (reset && (n % 8 == 0)) begin
            sym = (n >= 8 * SYNC_COUNT && bus.valid_in) ? bus.data_in : COM;
            for (int b = 7; b >= 0; b--) q.push_back(sym[b]);
        end
        @(posedge clk_32f);
        #1;
        if (!reset) begin
            q.delete();
            n       = 0;
            exp_do  = 1'b0;
            exp_act = 1'b0;
        end else begin
            exp_do  = (q.size() > 0) ? q.pop_front() : 1'b0;
            exp_act = (n >= 8 * (SYNC_COUNT - 1));
            n++;
        end
        check("data_out", 32'(bus.data_out), 32'(exp_do));
        check("active", 32'(bus.active), 32'(exp_act));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) tick();
        reset = 1'b1;
    endtask

    // Send one symbol slot; inputs scrambled off the load edge to show they
    // are ignored there.
    task automatic send_sym(input logic v, input logic [7:0] d, output logic [7:0] got);
        got = '0;
        bus.valid_in = v;
        bus.data_in  = d;
        tick();
        got = {got[6:0], bus.data_out};
        for (int i = 1; i < 8; i++) begin
            bus.valid_in = 1'($urandom);
            bus.data_in  = 8'($urandom);
            tick();
            got = {got[6:0], bus.data_out};
        end
    endtask

    initial begin
        logic [7:0] got;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'hBC, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'hBC, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'hBC, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'hBC, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'hBC, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'h55, 8'hBC, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h55, 8'hBC, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h55, 8'hBC, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'h55, 8'hBC, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'h55, 8'h55, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'h3C, 8'hBC, 1'b1};

        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;

        // Symbol table: sync, data, back-to-back, re-sync with valid held.
        for (int k = 0; k < 14; k++) begin
            if (vecs[k].rst_before) begin
                bus.valid_in = vecs[k].valid;
                bus.data_in  = vecs[k].data;
                do_reset(3);
                check("rst_active", 32'(bus.active), 32'h0);
                check("rst_data_out", 32'(bus.data_out), 32'h0);
            end
            send_sym(vecs[k].valid, vecs[k].data, got);
            check($sformatf("vec%0d_sym", k), 32'(got), 32'(vecs[k].exp_sym));
            check($sformatf("vec%0d_active", k), 32'(bus.active), 32'(vecs[k].exp_act));
        end

        // Mid-symbol change of data_in/valid_in while 0x00 is in flight.
        got = '0;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                bus.valid_in = 1'b0;
                bus.data_in  = 8'h3C;
            end
            if (i == 5) bus.valid_in = 1'b1;
            tick();
            got = {got[6:0], bus.data_out};
        end
        check("midsym_hold", 32'(got), 32'h00);
        send_sym(1'b0, 8'h3C, got);
        check("idle_com", 32'(got), 32'hBC);

        // Reset in the middle of 0xFF aborts it and restarts sync.
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hFF;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("abort_data_out", 32'(bus.data_out), 32'h0);
        check("abort_active", 32'(bus.active), 32'h0);
        tick();
        reset = 1'b1;
        for (int s = 0; s < SYNC_COUNT; s++) begin
            send_sym(1'b1, 8'h5A, got);
            check($sformatf("resync%0d_sym", s), 32'(got), 32'hBC);
            check($sformatf("resync%0d_active", s), 32'(bus.active), 32'(s == SYNC_COUNT - 1));
        end
        send_sym(1'b1, 8'h5A, got);
        check("post_resync_data", 32'(got), 32'h5A);

        // Random traffic with occasional resets, checked by the model.
        for (int t = 0; t < 3000; t++) begin
            reset        = ($urandom_range(0, 299) != 0);
            bus.valid_in = ($urandom_range(0, 3) != 0);
            bus.data_in  = 8'($urandom);
            tick();
        end
        reset = 1'b1;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/par_serial_tx.md
Name: par_serial_tx

Overview:
Transmit-lane serializer sitting directly downstream of the 32-to-8 converter. Takes its 8-bit data/valid output and shifts it out MSB-first, one bit per clock, on the 32f clock. Sends the COM symbol (K28.5, 8'hBC) when no valid byte is offered. After reset it transmits a fixed number of COM symbols before it accepts data.

Parameters:
DATA_W, 8, symbol width in bits; only 8 is supported.
COM_SYM, 8'hBC, symbol sent when idle or in sync.
SYNC_COUNT, 4, number of COM symbols sent after reset before data is accepted (>=1).

Ports:
clk_32f  input  1  bit clock; 8x the byte rate.
reset  input  1  synchronous, active-low reset.
data_in  input  DATA_W  byte from the 32-to-8 stage.
valid_in  input  1  data_in valid; sampled only on load edges.
data_out  output  1  serial bit, registered.
load_strb  output  1  combinational; high when data_in/valid_in are sampled at this edge.
active  output  1  registered; high once sync is done and data is being accepted.

Behaviour:
- Single clock, clk_32f. Reset is synchronous, active-low, and named reset. All state updates occur on the posedge.
- Reset (reset==0 at an edge):
  - bit_cnt<=0, sync_cnt<=0, state<=SYNC, shift<=0.
  - data_out<=0, active<=0.
  - load_strb is held 0 while reset is low.
- bit_cnt is 3 bits, increments every cycle and wraps 7->0. A load edge is any edge with bit_cnt==0 and reset==1; load_strb=(bit_cnt==0)&&reset.
- Load edge:
  - next_sym = (state==ACTIVE && valid_in) ? data_in : COM_SYM.
  - data_out<=next_sym[7]; shift<={next_sym[6:0],1'b0}.
- Non-load edge: data_out<=shift[7]; shift<=shift<<1.
- Latency: a byte sampled at load edge E appears on data_out bit7..bit0 after edges E..E+7. The next load edge is E+8, so symbols go out back-to-back with no gaps.
- FSM:
  - SYNC: at each load edge, sync_cnt++. At the load edge where sync_cnt==SYNC_COUNT-1, state<=ACTIVE and active<=1.
  - ACTIVE: stays here until reset. valid_in is ignored in SYNC and on non-load edges.
- data_in and valid_in changes between load edges have no effect on the symbol currently being shifted.
- Reset mid-symbol aborts the symbol immediately:
  - data_out is 0 after that edge.
  - The first cycle after release is a load edge, and the full SYNC sequence is repeated.
- Upstream is expected to align its byte updates to load_strb. No backpressure exists; a byte not present on a load edge is lost.

Decomposition:
- Shared package pcie_phy_pkg holds:
  - COM_SYM (8'hBC) and DATA_W;
  - state encoding localparams ST_SYNC and ST_ACTIVE.
  The byte-level stages reuse these.
- One natural sub-module, piso_shift8: an 8-bit parallel-load shift register with inputs load and din[7:0], output dout. par_serial_tx holds the FSM, bit counter and symbol mux.

Test Plan:
1. Reset low 3 cycles, then high with valid_in=0:
   - data_out = 10111100 repeated 4 times over edges 0..31;
   - active rises after edge 24;
   - load_strb is high at edges 0, 8, 16, 24, 32.
2. Hold valid_in=1, data_in=8'hA5 from edge 31 until edge 32 → data_out=1,0,1,0,0,1,0,1 after edges 32..39.
3. Back-to-back bytes 8'h00 then 8'hFF at load edges 40 and 48 → eight 0s then eight 1s with no COM between. Then valid_in=0 at edge 56 → 10111100.
4. Toggle valid_in and change data_in to 8'h3C at edge 43 (mid-symbol, 0x00 in flight) → bits after edges 43..47 remain 0; the byte is not sampled.
5. Assert reset at edge 51 (mid 0xFF) → after edge 51, data_out=0 and active=0. After release, 4 COM symbols are sent again and active returns 24 edges after the first post-release load.
6. Set valid_in=1 with data_in=8'h55 during SYNC edges 0..24 → output stays all COM; 8'h55 appears only from load edge 32.
